// File: rtl/alarm_ctrl_fsm.sv
// Alarm clock key-entry controller: collects digits, commits them as new time or alarm time.
// Latency: load pulses one cycle after the sampling edge; all outputs decoded from registers.
// No backpressure: key/tick strobes are consumed on the edge they appear. Option: TIME_CHECK_EN.
module alarm_ctrl_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] key_buffer_ms_hr,
  output logic [3:0] key_buffer_ls_hr,
  output logic [3:0] key_buffer_ms_min,
  output logic [3:0] key_buffer_ls_min,
  output logic       load_new_c,
  output logic       load_new_a,
  output logic       show_new_time,
  output logic       show_a
);

  typedef enum logic [2:0] {
    SHOW_TIME  = 3'd0,
    KEY_ENTRY  = 3'd1,
    SHOW_ALARM = 3'd2,
    SET_TIME   = 3'd3,
    SET_ALARM  = 3'd4
  } state_t;

  typedef struct packed {
    logic [3:0] ms_hr;
    logic [3:0] ls_hr;
    logic [3:0] ms_min;
    logic [3:0] ls_min;
  } key_buf_t;

  localparam logic [3:0] KEY_ALARM  = 4'hA;
  localparam logic [3:0] KEY_TIME   = 4'hB;
  localparam logic [3:0] TIMEOUT_LAST = 4'd9;

  state_t   state, state_nxt;
  key_buf_t key_buf, key_buf_nxt, key_buf_shift;
  logic [3:0] timer, timer_nxt;
  logic     is_digit, is_alarm, is_time;
  logic     key_acc;
  logic     buf_valid;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_alarm = key_valid && (key_code == KEY_ALARM);
  assign is_time  = key_valid && (key_code == KEY_TIME);

  assign key_buf_shift = '{ms_hr: key_buf.ls_hr, ls_hr: key_buf.ms_min,
                           ms_min: key_buf.ls_min, ls_min: key_code};

`ifdef TIME_CHECK_EN
  // Hour is two BCD digits, so "> 23" means tens above 2, or tens 2 with units above 3.
  assign buf_valid = !((key_buf.ms_hr > 4'd2) ||
                       ((key_buf.ms_hr == 4'd2) && (key_buf.ls_hr > 4'd3)) ||
                       (key_buf.ms_min > 4'd5) || (key_buf.ls_min > 4'd9));
`else
  assign buf_valid = 1'b1;
`endif

  always_comb begin
    state_nxt   = state;
    key_buf_nxt = key_buf;
    timer_nxt   = timer;
    key_acc     = 1'b0;
    case (state)
      SHOW_TIME: begin
        if (is_digit) begin
          key_buf_nxt = key_buf_shift;
          state_nxt   = KEY_ENTRY;
          key_acc     = 1'b1;
        end else if (is_alarm) begin
          state_nxt = SHOW_ALARM;
          key_acc   = 1'b1;
        end
      end
      SHOW_ALARM: begin
        if (is_alarm) begin
          state_nxt = SHOW_TIME;
          key_acc   = 1'b1;
        end else if (is_digit) begin
          key_buf_nxt = key_buf_shift;
          state_nxt   = KEY_ENTRY;
          key_acc     = 1'b1;
        end else if (one_second) begin
          if (timer == TIMEOUT_LAST) state_nxt = SHOW_TIME;
          else                       timer_nxt = timer + 4'd1;
        end
      end
      KEY_ENTRY: begin
        if (is_digit) begin
          key_buf_nxt = key_buf_shift;
          key_acc     = 1'b1;
        end else if (is_time || is_alarm) begin
          key_acc = 1'b1;
          if (!buf_valid) begin
            state_nxt   = SHOW_TIME;
            key_buf_nxt = '0;
          end else begin
            state_nxt = is_time ? SET_TIME : SET_ALARM;
          end
        end else if (one_second) begin
          if (timer == TIMEOUT_LAST) begin
            state_nxt   = SHOW_TIME;
            key_buf_nxt = '0;
          end else begin
            timer_nxt = timer + 4'd1;
          end
        end
      end
      SET_TIME, SET_ALARM: begin
        // Buffer stays intact during the pulse so the load captures it, then clears.
        state_nxt   = SHOW_TIME;
        key_buf_nxt = '0;
      end
      default: state_nxt = SHOW_TIME;
    endcase
    if (key_acc || (state_nxt != state)) timer_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SHOW_TIME;
      key_buf <= '0;
      timer   <= '0;
    end else begin
      state   <= state_nxt;
      key_buf <= key_buf_nxt;
      timer   <= timer_nxt;
    end
  end

  assign key_buffer_ms_hr  = key_buf.ms_hr;
  assign key_buffer_ls_hr  = key_buf.ls_hr;
  assign key_buffer_ms_min = key_buf.ms_min;
  assign key_buffer_ls_min = key_buf.ls_min;
  assign load_new_c    = (state == SET_TIME);
  assign load_new_a    = (state == SET_ALARM);
  assign show_new_time = (state == KEY_ENTRY);
  assign show_a        = (state == SHOW_ALARM);

endmodule
